// File: rtl/ram_wb_adapter_pkg.sv
// Shared memory package: adapter FSM encoding and RAM block geometry.
package ram_wb_adapter_pkg;

  localparam int unsigned BLOCK_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } mem_state_e;

endpackage

// File: rtl/ram_wb_adapter.sv
// Wishbone classic slave mapping a 32 KB window onto a synchronous 32-bit RAM port.
// Handshake: a request is taken when cyc&stb are high in IDLE; wb_ack_o pulses for one cycle.
module ram_wb_adapter
  import ram_wb_adapter_pkg::*;
#(
  parameter int unsigned BLOCKS = 6,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        ram_EN,
  output logic [3:0]  ram_WE,
  output logic [12:0] ram_A,
  output logic [31:0] ram_Di,
  input  logic [31:0] ram_Do,
  output mem_state_e  state_dbg
);

  localparam logic [13:0] WORD_LIMIT = 14'(BLOCKS * BLOCK_WORDS);

  mem_state_e  state, state_next;
  logic        hit, in_range, capture, load_zero;
  logic [12:0] offset;
  logic [31:0] dat_q;
  logic        unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign hit      = wb_cyc_i & wb_stb_i & (wb_adr_i[31:15] == BASE[31:15]);
  assign offset   = wb_adr_i[14:2];
  assign in_range = ({1'b0, offset} < WORD_LIMIT);

  // Gated by RST_N so the RAM stays idle while reset is held, even with a live request.
  assign ram_EN = RST_N & (state == IDLE) & hit & in_range;
  assign ram_WE = (ram_EN & wb_we_i) ? wb_sel_i : 4'b0000;
  assign ram_A  = offset;
  assign ram_Di = wb_dat_i;

  assign wb_ack_o  = (state == ACK);
  assign wb_dat_o  = dat_q;
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      dat_q <= 32'h0;
    end else begin
      state <= state_next;
      if (load_zero) begin
        dat_q <= 32'h0;
      end else if (capture) begin
        dat_q <= ram_Do;
      end
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    load_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          if (in_range && !wb_we_i) begin
            state_next = RD_WAIT;
          end else begin
            // Out-of-range reads return zero; out-of-range writes are dropped.
            state_next = ACK;
            load_zero  = !wb_we_i && !in_range;
          end
        end
      end
      RD_WAIT: begin
        if (wb_cyc_i) begin
          capture    = 1'b1;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/ram_wb_adapter.md
RAM_WB_ADAPTER -- requirements
Module: ram_wb_adapter

Interface
REQ-001 Parameter BLOCKS, default 6: number of populated 1K-word blocks behind the RAM port; legal range 1..8.
REQ-002 Parameter BASE, default 32'h0000_0000: byte base address of the RAM window; must be 32 KB aligned.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 wb_cyc_i  input  1  Wishbone classic bus cycle.
REQ-006 wb_stb_i  input  1  Wishbone strobe.
REQ-007 wb_we_i  input  1  1 = write, 0 = read.
REQ-008 wb_sel_i  input  4  byte lane selects; bit n covers bits [8n+7:8n].
REQ-009 wb_adr_i  input  32  byte address.
REQ-010 wb_dat_i  input  32  write data.
REQ-011 wb_dat_o  output  32  registered read data.
REQ-012 wb_ack_o  output  1  registered acknowledge.
REQ-013 ram_EN  output  1  RAM enable.
REQ-014 ram_WE  output  4  RAM byte write enables.
REQ-015 ram_A  output  13  RAM word address.
REQ-016 ram_Di  output  32  RAM write data.
REQ-017 ram_Do  input  32  RAM read data, valid after the CLK edge that samples ram_EN=1.

Function
REQ-018 Hit = wb_cyc_i & wb_stb_i & (wb_adr_i[31:15] == BASE[31:15]).
REQ-019 Window offset = wb_adr_i[14:2]; in range when offset < BLOCKS*1024; bits [1:0] are ignored.
REQ-020 FSM states: IDLE, RD_WAIT, ACK; reset state IDLE.
REQ-021 In IDLE, on an in-range hit, drive combinationally in the same cycle: ram_EN=1, ram_A=offset, ram_Di=wb_dat_i, ram_WE=(wb_we_i ? wb_sel_i : 4'b0).
REQ-022 In every other case, ram_EN=0 and ram_WE=0; ram_A and ram_Di carry don't-care values.
REQ-023 Write hit: go IDLE->ACK; wb_ack_o=1 exactly one cycle after the request cycle.
REQ-024 Read hit: go IDLE->RD_WAIT->ACK. In RD_WAIT, ram_Do is captured into wb_dat_o. wb_ack_o=1 exactly two cycles after the request cycle.
REQ-025 Out-of-range hit: no RAM access; go IDLE->ACK; a read returns wb_dat_o=32'h0 and a write is discarded.
REQ-026 ACK lasts exactly one cycle, then IDLE. wb_stb_i is ignored while in ACK, so there are no back-to-back duplicate accesses.
REQ-027 wb_dat_o holds its value until the next read capture.
REQ-028 If wb_cyc_i deasserts in RD_WAIT or ACK: return to IDLE next cycle with wb_ack_o=0. A write committed at the request edge stays committed.
REQ-029 Write with wb_sel_i=4'b0: RAM enabled with ram_WE=0, memory unchanged, acked normally.
REQ-030 Sustained throughput: writes 1 per 2 cycles, reads 1 per 3 cycles.

Reset
REQ-031 While RST_N=0: state=IDLE, wb_ack_o=0, wb_dat_o=32'h0, ram_EN=0, ram_WE=4'b0, all asynchronous.
REQ-032 Reset asserted mid-transaction abandons it with no ack; a RAM write already issued is not undone.
REQ-033 First access is accepted in the first cycle after RST_N rises.

Structure
REQ-034 FSM state encoding and the 1024-word block-size constant live in the shared memory package.
REQ-035 No sub-modules; single flat module. The bench instantiates it with the 8Kx32 RAM macro.

Verification
REQ-036 Write 32'hDEADBEEF with sel=4'hF at byte 0x0000_0010 -> ram_A=4, ram_WE=4'hF in the request cycle, ack one cycle later; a subsequent read returns 32'hDEADBEEF with ack two cycles after the request.
REQ-037 Write 32'h11223344 with sel=4'b0101 over 32'hFFFFFFFF at word 7 -> readback 32'hFF22FF44.
REQ-038 BLOCKS=6, read at byte 0x0000_6000 (word 6144) -> no ram_EN, ack one cycle later, data 32'h0; a write there leaves word 0 unchanged.
REQ-039 Read address with [31:15] != BASE[31:15] -> no ack and no ram_EN for 10 cycles.
REQ-040 Drop wb_cyc_i in RD_WAIT -> no ack; the next read (word 1) is acked with the correct data.
REQ-041 Assert RST_N=0 in ACK -> wb_ack_o falls immediately without waiting for CLK; wb_dat_o=0; the access after reset completes normally.
